// File: rtl/condlogic_pkg.sv
// Shared definitions for the conditional-execution unit: condition codes and
// NZCV bit positions.
package cond_pkg;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/condlogic_if.sv
// FSM-to-condlogic bus: raw strobes and condition inputs in, gated enables out.
interface condlogic_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondExDly;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite, Flags, CondExDly
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    output PCWrite, RegWrite, MemWrite, Flags, CondExDly
  );
endinterface

// File: rtl/condlogic_cond_check.sv
// Combinational evaluation of a 4-bit ARM condition field against NZCV.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);
  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = !z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = !c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = !n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = !v;
      COND_HI: CondEx = c & !z;
      COND_LS: CondEx = !c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = !ge;
      COND_GT: CondEx = !z & ge;
      COND_LE: CondEx = z | !ge;
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end
endmodule

// File: rtl/condlogic.sv
// Conditional-execution unit: NZCV register, registered pass/fail, and gating
// of the FSM write strobes into architectural enables.
module condlogic
  import cond_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  condlogic_if.slave bus
);
  logic [3:0] flags_q;
  logic       cond_ex;
  logic       cond_ex_dly;
  logic [1:0] flag_write;

  cond_check u_cond_check (
    .Cond   (bus.Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  // A failing condition also blocks the instruction's own flag update.
  assign flag_write = bus.FlagW & {2{cond_ex}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q     <= 4'b0000;
      cond_ex_dly <= 1'b0;
    end else begin
      cond_ex_dly <= cond_ex;
      if (flag_write[1]) flags_q[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
      if (flag_write[0]) flags_q[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // Write-back states see the decision made before this instruction's flag write.
  assign bus.PCWrite   = (bus.PCS & cond_ex_dly) | bus.NextPC;
  assign bus.RegWrite  = bus.RegW & cond_ex_dly;
  assign bus.MemWrite  = bus.MemW & cond_ex_dly;
  assign bus.Flags     = flags_q;
  assign bus.CondExDly = cond_ex_dly;
endmodule

// File: doc/condlogic.md
# condlogic

Conditional-execution unit of the multicycle ARM controller, directly downstream of the main FSM. Holds the NZCV status flags, evaluates the instruction's 4-bit condition field against them, and gates the FSM's raw write strobes (RegW, MemW, Branch/PCS) into the architectural write enables that drive the register file, memory and PC register. The pass/fail decision is registered, so gating in later states uses the flags as they were before the current instruction's own flag update.

## Interface
Parameters: none.

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- Cond  in  4  Instr[31:28], stable from DECODE until the next FETCH
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- FlagW  in  2  from the ALU decoder: [1] updates N,Z; [0] updates C,V; high only in execute cycles
- PCS  in  1  PC written by the instruction (Branch, or Rd==15 with RegW)
- NextPC  in  1  FSM PC increment (FETCH); never condition-gated
- RegW  in  1  FSM register-write strobe
- MemW  in  1  FSM memory-write strobe
- PCWrite  out  1  PC register enable
- RegWrite  out  1  register-file write enable
- MemWrite  out  1  data-memory write enable
- Flags  out  4  current {N,Z,C,V} register, for debug/trace
- CondExDly  out  1  registered condition result

## Operation
- CondEx (combinational) = condition evaluation of Cond on the Flags register: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0 (never).
- Flag write: FlagWrite[1] = FlagW[1]&CondEx loads N,Z from ALUFlags[3:2]; FlagWrite[0] = FlagW[0]&CondEx loads C,V from ALUFlags[1:0]; halves independent.
- CondExDly <= CondEx every cycle (no enable).
- PCWrite = (PCS & CondExDly) | NextPC; RegWrite = RegW & CondExDly; MemWrite = MemW & CondExDly. Purely combinational on registered CondExDly and current strobes.
- Failed condition: instruction still walks all FSM states; only architectural writes and flag updates are suppressed.

## Timing
- Reset (reset=0, async): Flags=4'b0000, CondExDly=0; hence RegWrite=MemWrite=0 and PCWrite=NextPC during and after reset. Reset mid-instruction discards all pending gating.
- Latency: Cond/Flags to CondExDly 1 cycle. Condition evaluated in DECODE/EXECUTE is applied in MEMWR, MEMWB, ALUWB and the cycle after BRANCH.
- Flags update at end of the execute cycle; the following write-back cycle sees old-flag CondExDly (CMP-like instructions never gate themselves on their own result).
- Simultaneous FlagW and condition fail: flags unchanged.
- Cond=1111 with FlagW set: no flag write, no strobes.
- NextPC high with CondExDly=0: PCWrite=1 (fetch unaffected).

## Structure
- Shared package (cond_pkg): condition-code localparams COND_EQ..COND_NV, flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module cond_check (Cond, Flags -> CondEx); top holds flag register, CondExDly flop and gating.

## Test plan
- Reset: hold reset=0 with RegW=MemW=1, NextPC=0 -> Flags=0000, RegWrite=MemWrite=PCWrite=0; release, NextPC=1 -> PCWrite=1.
- Flag update: Cond=1110, FlagW=11, ALUFlags=0100 for one cycle -> Flags=0100 next cycle; then FlagW=01, ALUFlags=1011 -> Flags=0111 (N,Z kept).
- Condition sweep: for each Cond 0000-1111 and all 16 Flags values, check CondExDly one cycle later against the table (e.g. Flags=1001, Cond=1010 GE -> 1; Cond=1101 LE -> 0).
- Gating: Flags Z=0, Cond=0000 EQ, next cycle RegW=1, MemW=1, PCS=1 -> RegWrite=MemWrite=PCWrite=0; same with Z=1 -> all 1.
- Own-flag ordering: Flags=0000, Cond=0001 NE, FlagW=11 with ALUFlags=0100 in execute, RegW=1 next cycle -> RegWrite=1 (old Z used), Flags=0100.
- Reset mid-op: CondExDly=1, assert reset low asynchronously mid-cycle with RegW=1 -> RegWrite drops to 0 without a clock edge.
